uart_host_bridge: RTL
=====================

Name: uart_host_bridge

Overview:
Host-side companion to the UART core: the other end of the core's parallel tx/rx interface. Buffers host bytes in a TX FIFO and sequences the core's tx_start/tx_busy handshake one frame at a time. Captures each rx_ready pulse (data plus error) into an RX FIFO with valid/ready readout. Owns the core's ctrl_word and changes it only between frames.

Parameters:
TX_DEPTH, 8, TX FIFO entries (power of 2, >=2)
RX_DEPTH, 8, RX FIFO entries (power of 2, >=2); each entry is {err, data[7:0]}

Ports:
clk  in  1  clock
rst  in  1  reset
tx_wdata  in  8  host byte to send
tx_wvalid  in  1  host write request
tx_wready  out  1  TX FIFO not full
rx_rdata  out  8  RX FIFO head data
rx_rerr  out  1  RX FIFO head error flag
rx_rvalid  out  1  RX FIFO not empty
rx_rready  in  1  host pops RX head
cfg_ctrl  in  5  requested ctrl_word
cfg_load  in  1  one-cycle request to apply cfg_ctrl
cfg_pending  out  1  load requested, not yet applied
ovr_clr  in  1  clear rx_overrun
rx_overrun  out  1  sticky: RX byte dropped (FIFO full)
tx_level  out  clog2(TX_DEPTH)+1  TX FIFO occupancy
rx_level  out  clog2(RX_DEPTH)+1  RX FIFO occupancy
core_ctrl_word  out  5  to core ctrl_word
core_tx_data  out  8  to core tx_data
core_tx_start  out  1  to core tx_start
core_tx_busy  in  1  from core tx_busy
core_rx_data  in  8  from core rx_data
core_rx_ready  in  1  from core rx_ready (1-cycle pulse)
core_rx_error  in  1  from core rx_error

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. Reset values:
  - Both FIFOs empty; levels 0; tx_wready=1; rx_rvalid=0.
  - rx_rdata=0, rx_rerr=0, rx_overrun=0, cfg_pending=0.
  - core_tx_start=0, core_tx_data=0.
  - core_ctrl_word=5'b01011 (8 data bits, no parity, 1 stop).
  - TX FSM in T_IDLE.
- Reset mid-frame aborts the sequence and discards all FIFO contents.
- TX FIFO:
  - Write when tx_wvalid & tx_wready.
  - tx_wready = !full, computed from the registered count; a write while full is ignored even if a pop occurs the same cycle.
- TX FSM, all outputs registered:
  - T_IDLE: if FIFO non-empty & !cfg_pending & !core_tx_busy -> T_LAUNCH. At that edge, core_tx_data <= FIFO head and pop.
  - T_LAUNCH: core_tx_start=1 for exactly this one cycle -> T_ARM.
  - T_ARM: core_tx_busy rises 2 cycles after the start edge (the core registers busy). Wait for core_tx_busy=1 -> T_DRAIN.
  - T_DRAIN: wait for core_tx_busy=0 -> T_IDLE.
  - core_tx_data holds stable until the next launch.
  - Minimum gap from busy falling to the next core_tx_start is 2 cycles.
- Config:
  - cfg_load sets cfg_pending and captures cfg_ctrl; a later cfg_load before apply overwrites the captured value.
  - The captured value is applied to core_ctrl_word when the FSM is in T_IDLE with core_tx_busy=0; cfg_pending clears at the same edge.
  - While cfg_pending=1, no new frame launches.
  - The host must not load while RX reception is in progress; the bridge does not police this.
- RX capture:
  - On core_rx_ready, push {core_rx_error, core_rx_data}.
  - Pop when rx_rvalid & rx_rready; rx_rdata/rx_rerr show the head combinationally from FIFO storage.
  - Push while full with a simultaneous pop: accepted, level unchanged, no overrun.
  - Push while full without a pop: byte dropped, rx_overrun <= 1.
  - ovr_clr clears rx_overrun; if set and clear occur in the same cycle, set wins.
- Pointers wrap modulo depth. Levels update one cycle after the push or pop.

Test Plan:
- Reset, then read outputs -> core_ctrl_word=0x0B, tx_wready=1, rx_rvalid=0, levels 0, core_tx_start=0.
- Write 0x55, 0xA3 back-to-back; model core busy (rises 2 cycles after start, holds 160 cycles) -> start pulses exactly 1 cycle each; core_tx_data=0x55 then 0xA3; second start not before 2 cycles after busy falls; tx_level returns to 0.
- Write 9 bytes with busy held high (TX_DEPTH=8) -> first byte launches; 8 more accepted; tx_wready=0 at level 8; a 10th write is ignored.
- Pulse core_rx_ready 9 times with rx_rready=0 (0x10..0x18, error on 0x12) -> rx_level=8, rx_overrun=1, 0x18 dropped; readout gives 0x10..0x17 with rx_rerr=1 only on 0x12.
- Full RX FIFO, core_rx_ready coincident with a pop -> no overrun, level stays 8, new byte appended. ovr_clr coincident with an overflow -> rx_overrun stays 1.
- cfg_load=0x1F during an active frame -> cfg_pending=1 and queued byte held; core_ctrl_word changes to 0x1F only after busy falls; queued byte then launches.

Source files
------------

// File: rtl/uart_host_bridge.sv
// Host-side bridge for the UART core: TX FIFO with frame-by-frame tx_start/tx_busy
// sequencing, RX FIFO capture with sticky overrun, and between-frame ctrl_word updates.
module uart_host_bridge #(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  tx_wdata,
  input  logic                        tx_wvalid,
  output logic                        tx_wready,
  output logic [7:0]                  rx_rdata,
  output logic                        rx_rerr,
  output logic                        rx_rvalid,
  input  logic                        rx_rready,
  input  logic [4:0]                  cfg_ctrl,
  input  logic                        cfg_load,
  output logic                        cfg_pending,
  input  logic                        ovr_clr,
  output logic                        rx_overrun,
  output logic [$clog2(TX_DEPTH):0]   tx_level,
  output logic [$clog2(RX_DEPTH):0]   rx_level,
  output logic [4:0]                  core_ctrl_word,
  output logic [7:0]                  core_tx_data,
  output logic                        core_tx_start,
  input  logic                        core_tx_busy,
  input  logic [7:0]                  core_rx_data,
  input  logic                        core_rx_ready,
  input  logic                        core_rx_error
);

  // state    | meaning
  // T_IDLE   | no frame in flight; may apply config or launch the FIFO head
  // T_LAUNCH | core_tx_start high for this single cycle
  // T_ARM    | waiting for the core to raise tx_busy
  // T_DRAIN  | frame on the line; waiting for tx_busy to fall

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [TAW:0]   TX_FULL    = (TAW+1)'(TX_DEPTH);
  localparam logic [RAW:0]   RX_FULL    = (RAW+1)'(RX_DEPTH);
  localparam logic [TAW:0]   TX_CNT_ONE = (TAW+1)'(1);
  localparam logic [RAW:0]   RX_CNT_ONE = (RAW+1)'(1);
  localparam logic [TAW-1:0] TX_PTR_ONE = TAW'(1);
  localparam logic [RAW-1:0] RX_PTR_ONE = RAW'(1);
  localparam logic [4:0]     CTRL_RESET = 5'b01011;

  typedef enum logic [1:0] {T_IDLE, T_LAUNCH, T_ARM, T_DRAIN} tx_state_t;

  tx_state_t state, state_next;
  logic launch, apply;

  // TX FIFO
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TAW-1:0] tx_wp, tx_rp;
  logic [TAW:0]   tx_cnt;
  logic           tx_full, tx_empty, tx_push;

  assign tx_full   = (tx_cnt == TX_FULL);
  assign tx_empty  = (tx_cnt == '0);
  assign tx_wready = ~tx_full;
  assign tx_push   = tx_wvalid & ~tx_full;
  assign tx_level  = tx_cnt;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= tx_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + TX_PTR_ONE;
      if (launch)  tx_rp <= tx_rp + TX_PTR_ONE;
      case ({tx_push, launch})
        2'b10:   tx_cnt <= tx_cnt + TX_CNT_ONE;
        2'b01:   tx_cnt <= tx_cnt - TX_CNT_ONE;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  // TX sequencer
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    apply      = 1'b0;
    case (state)
      T_IDLE: begin
        if (cfg_pending && !core_tx_busy) apply = 1'b1;
        if (!tx_empty && !cfg_pending && !core_tx_busy) begin
          launch     = 1'b1;
          state_next = T_LAUNCH;
        end
      end
      T_LAUNCH: state_next = T_ARM;
      T_ARM:    if (core_tx_busy) state_next = T_DRAIN;
      T_DRAIN:  if (!core_tx_busy) state_next = T_IDLE;
      default:  state_next = T_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= T_IDLE;
      core_tx_start <= 1'b0;
      core_tx_data  <= 8'h00;
    end else begin
      state         <= state_next;
      core_tx_start <= launch;
      if (launch) core_tx_data <= tx_mem[tx_rp];
    end
  end

  // Config shadow: a load in the same cycle as an apply queues the newer value
  logic [4:0] cfg_shadow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_shadow     <= CTRL_RESET;
      cfg_pending    <= 1'b0;
      core_ctrl_word <= CTRL_RESET;
    end else begin
      if (apply) core_ctrl_word <= cfg_shadow;
      if (cfg_load) begin
        cfg_shadow  <= cfg_ctrl;
        cfg_pending <= 1'b1;
      end else if (apply) begin
        cfg_pending <= 1'b0;
      end
    end
  end

  // RX FIFO
  logic [8:0]     rx_mem [RX_DEPTH];
  logic [RAW-1:0] rx_wp, rx_rp;
  logic [RAW:0]   rx_cnt;
  logic           rx_full, rx_pop, rx_push, ovr_set;
  logic [8:0]     rx_head;

  assign rx_full   = (rx_cnt == RX_FULL);
  assign rx_rvalid = (rx_cnt != '0);
  assign rx_pop    = rx_rvalid & rx_rready;
  assign rx_push   = core_rx_ready & (~rx_full | rx_pop);
  assign ovr_set   = core_rx_ready & rx_full & ~rx_pop;
  assign rx_head   = rx_rvalid ? rx_mem[rx_rp] : 9'h000;
  assign rx_rdata  = rx_head[7:0];
  assign rx_rerr   = rx_head[8];
  assign rx_level  = rx_cnt;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= {core_rx_error, core_rx_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wp      <= '0;
      rx_rp      <= '0;
      rx_cnt     <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + RX_PTR_ONE;
      if (rx_pop)  rx_rp <= rx_rp + RX_PTR_ONE;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + RX_CNT_ONE;
        2'b01:   rx_cnt <= rx_cnt - RX_CNT_ONE;
        default: rx_cnt <= rx_cnt;
      endcase
      if (ovr_set)      rx_overrun <= 1'b1;
      else if (ovr_clr) rx_overrun <= 1'b0;
    end
  end

endmodule
